// File: rtl/bus_arbiter_rr_pkg.sv
// Shared bus package: bus-wide constants and arbiter FSM encoding.
// Imported by the round-robin arbiter and its priority picker.
package bus_arbiter_rr_pkg;

   localparam int BUS_NUM_MASTERS = 12;
   localparam int BUS_NUM_SLAVES  = 6;
   localparam int BUS_MID_WIDTH   = 4;
   localparam int BUS_OH_ID_W     = $clog2(BUS_NUM_MASTERS);
   localparam int BUS_ACK_TIMEOUT = 8;
   localparam int BUS_HOLD_LEN    = 10;
   localparam int BUS_UTIL_CNT_W  = 16;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WAIT_ACK = 4'd1,
      ST_BUSY     = 4'd2,
      ST_RELEASE  = 4'd3
   } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner search: first requester strictly after
// last_mid, scanning upward and wrapping to index 0.
module rr_priority_picker
   import bus_arbiter_rr_pkg::*;
#(
   parameter int NUM_MASTERS = BUS_NUM_MASTERS,
   parameter int MID_WIDTH   = BUS_MID_WIDTH
) (
   input  logic [NUM_MASTERS-1:0] reqs,
   input  logic [MID_WIDTH-1:0]   last_mid,
   output logic                   valid,
   output logic [MID_WIDTH-1:0]   winner
);

   logic [BUS_OH_ID_W-1:0] w_idx;

   // Farthest slot first so the nearest requester overwrites last.
   always_comb begin
      valid  = 1'b0;
      winner = last_mid;
      w_idx  = '0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         w_idx = BUS_OH_ID_W'((int'(last_mid) + k) % NUM_MASTERS);
         if (reqs[w_idx]) begin
            valid  = 1'b1;
            winner = MID_WIDTH'(w_idx);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with ack timeout, bus-hold watchdog
// and saturating bus-utilisation counter.
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int NUM_MASTERS = BUS_NUM_MASTERS,
   parameter int MID_WIDTH   = BUS_MID_WIDTH,
   parameter int ACK_TIMEOUT = BUS_ACK_TIMEOUT,
   parameter int HOLD_LEN    = BUS_HOLD_LEN
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_MASTERS-1:0]    m_reqs,
   input  logic                      bus_util,
   input  logic [BUS_NUM_SLAVES-1:0] slaves,
   output logic [NUM_MASTERS-1:0]    m_grants,
   output logic [MID_WIDTH-1:0]      mid_current,
   output logic [3:0]                state,
   output logic                      timeout_err,
   output logic [MID_WIDTH-1:0]      err_mid,
   output logic [BUS_UTIL_CNT_W-1:0] busy_cycles
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [HOLD_LEN-1:0] HOLD_LAST =
      {{(HOLD_LEN-1){1'b1}}, 1'b0};
   localparam logic [MID_WIDTH-1:0] MID_LAST =
      MID_WIDTH'(NUM_MASTERS - 1);

   arb_state_t                r_state;
   logic [NUM_MASTERS-1:0]    r_grants;
   logic [MID_WIDTH-1:0]      r_mid_current;
   logic [MID_WIDTH-1:0]      r_last_mid;
   logic                      r_timeout_err;
   logic [MID_WIDTH-1:0]      r_err_mid;
   logic [ACK_W-1:0]          r_ack_cnt;
   logic [HOLD_LEN-1:0]       r_hold_cnt;
   logic [BUS_UTIL_CNT_W-1:0] r_busy_cycles;

   logic                 w_valid;
   logic [MID_WIDTH-1:0] w_winner;
   logic                 w_unused_status;

   // Slave busy lines are status only; they never steer arbitration.
   assign w_unused_status = ^slaves;

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .MID_WIDTH   (MID_WIDTH)
   ) u_picker (
      .reqs     (m_reqs),
      .last_mid (r_last_mid),
      .valid    (w_valid),
      .winner   (w_winner)
   );

   // Arbitration FSM; grant, IDs and error pulse are all registered.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= ST_IDLE;
         r_grants      <= '0;
         r_mid_current <= '0;
         r_last_mid    <= MID_LAST;
         r_timeout_err <= 1'b0;
         r_err_mid     <= '0;
         r_ack_cnt     <= '0;
         r_hold_cnt    <= '0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ack_cnt  <= '0;
               r_hold_cnt <= '0;
               if (w_valid) begin
                  r_grants      <= NUM_MASTERS'(1) << w_winner;
                  r_mid_current <= w_winner;
                  r_last_mid    <= w_winner;
                  r_state       <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (bus_util) begin
                  r_state    <= ST_BUSY;
                  r_ack_cnt  <= '0;
                  r_hold_cnt <= '0;
               end else if (!m_reqs[r_mid_current]) begin
                  r_state   <= ST_RELEASE;
                  r_grants  <= '0;
                  r_ack_cnt <= '0;
               end else if (r_ack_cnt == ACK_LAST) begin
                  r_state       <= ST_RELEASE;
                  r_grants      <= '0;
                  r_ack_cnt     <= '0;
                  r_timeout_err <= 1'b1;
                  r_err_mid     <= r_mid_current;
               end else begin
                  r_ack_cnt <= r_ack_cnt + 1'b1;
               end
            end
            ST_BUSY: begin
               if (!bus_util) begin
                  r_state    <= ST_RELEASE;
                  r_grants   <= '0;
                  r_hold_cnt <= '0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_state       <= ST_RELEASE;
                  r_grants      <= '0;
                  r_hold_cnt    <= '0;
                  r_timeout_err <= 1'b1;
                  r_err_mid     <= r_mid_current;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               r_state    <= ST_IDLE;
               r_ack_cnt  <= '0;
               r_hold_cnt <= '0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_grants   <= '0;
               r_ack_cnt  <= '0;
               r_hold_cnt <= '0;
            end
         endcase
      end
   end

   // Count every cycle the shared bus is driven, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_busy_cycles <= '0;
      end else if (bus_util && (r_busy_cycles != '1)) begin
         r_busy_cycles <= r_busy_cycles + 1'b1;
      end
   end

   assign m_grants    = r_grants;
   assign mid_current = r_mid_current;
   assign state       = r_state;
   assign timeout_err = r_timeout_err;
   assign err_mid     = r_err_mid;
   assign busy_cycles = r_busy_cycles;

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, 12, number of request/grant lines.
REQ-002 Parameter MID_WIDTH, 4, width of master ID outputs.
REQ-003 Parameter ACK_TIMEOUT, 8, cycles a granted master has to raise bus_util before the grant is withdrawn.
REQ-004 Parameter HOLD_LEN, 10, width in bits of the bus-hold watchdog counter (max 2^HOLD_LEN-1 cycles).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rstn  input  1  reset; synchronous and active-low.
REQ-007 m_reqs  input  NUM_MASTERS  per-master bus request, level, held until transaction done.
REQ-008 bus_util  input  1  shared bus-utilizing line, high while a master drives a transaction.
REQ-009 slaves  input  6  per-slave busy lines, used for status only.
REQ-010 m_grants  output  NUM_MASTERS  one-hot grant, all-zero when no grant.
REQ-011 mid_current  output  MID_WIDTH  ID of the granted master; holds the last granted ID when idle.
REQ-012 state  output  4  encoded FSM state for display.
REQ-013 timeout_err  output  1  one-cycle pulse on ack timeout or hold watchdog expiry.
REQ-014 err_mid  output  MID_WIDTH  ID of the master that caused the last timeout_err.
REQ-015 busy_cycles  output  16  saturating count of cycles with bus_util high.

Function
REQ-016 FSM states SHALL be IDLE=0, WAIT_ACK=1, BUSY=2, RELEASE=3; other codes unreachable and SHALL return to IDLE.
REQ-017 IDLE: when m_reqs != 0, the winner SHALL be the first requesting index strictly after last_mid, searched upward with wrap from NUM_MASTERS-1 to 0; the last winner has lowest priority.
REQ-018 Grant latency: m_grants one-hot and mid_current SHALL update on the edge after the request is sampled in IDLE; FSM enters WAIT_ACK on the same edge.
REQ-019 WAIT_ACK: grant held; bus_util high -> BUSY; winner's request low -> RELEASE, no error; ACK_TIMEOUT cycles without bus_util -> RELEASE with timeout_err pulse and err_mid = winner.
REQ-020 BUSY: grant held while bus_util high; bus_util falling -> RELEASE regardless of request level.
REQ-021 BUSY watchdog: hold counter reaching all-ones -> RELEASE with timeout_err pulse and err_mid = winner.
REQ-022 RELEASE: m_grants all-zero for exactly one turnaround cycle, then IDLE; no new grant may issue until IDLE is re-entered.
REQ-023 Grant changes SHALL occur only on entry to WAIT_ACK and on entry to RELEASE; never two grant bits high.
REQ-024 Requests arriving during WAIT_ACK/BUSY/RELEASE SHALL be held off, then arbitrated in IDLE.
REQ-025 Counters (ack, hold) SHALL clear on every state entry; busy_cycles saturates at 16'hFFFF, no wrap.
REQ-026 last_mid SHALL update only when a grant issues.

Reset
REQ-027 On rstn low at a clock edge: state IDLE, m_grants 0, mid_current 0, last_mid NUM_MASTERS-1 (so master 0 wins first), timeout_err 0, err_mid 0, busy_cycles 0, counters 0.
REQ-028 Reset asserted mid-transaction SHALL drop the grant on that edge; no timeout_err is produced.

Structure
REQ-029 State encodings, NUM_MASTERS, MID_WIDTH and the one-hot-to-ID conversion width SHALL live in the shared bus package alongside the existing bus constants.
REQ-030 The round-robin winner search SHALL be one combinational sub-module rr_priority_picker (inputs reqs, last_mid; outputs valid, winner ID).

Verification
REQ-031 After reset, m_reqs=12'h004, bus_util high 3 cycles after grant, low 20 cycles later -> m_grants=12'h004 next cycle, mid_current=2, RELEASE 1 cycle, IDLE, busy_cycles=20.
REQ-032 last_mid=2, m_reqs=12'h824 held, each grantee completes -> grant order 5, 11, 2, 5 (wrap verified).
REQ-033 m_reqs=12'h010, bus_util never rises -> grant held exactly 8 cycles, timeout_err one pulse, err_mid=4, grant low.
REQ-034 Granted master holds bus_util high 1023 cycles -> watchdog timeout_err, grant drop, FSM RELEASE then IDLE.
REQ-035 rstn low during BUSY with m_grants=12'h020 -> next edge m_grants=0, state=0, mid_current=0, no timeout_err.
REQ-036 Random requests/bus_util 10k cycles -> m_grants always one-hot or zero, every persistent requester granted within 11 arbitrations.
